ball_physics: RTL and testbench
===============================

BALL_PHYSICS -- requirements
Module: ball_physics

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-002 SHALL have port `resetn`, input, 1 bit: reset, synchronous and active-high (asserted = 1).
REQ-003 SHALL have port `frame_tick`, input, 1 bit: one-cycle pulse, once per video frame.
REQ-004 SHALL have port `serve`, input, 1 bit: level; launches the ball from IDLE.
REQ-005 SHALL have port `left_paddle_y`, input, 8 bits: top row of the left paddle.
REQ-006 SHALL have port `right_paddle_y`, input, 8 bits: top row of the right paddle (the AI paddle).
REQ-007 SHALL have port `ball_x`, output, 9 bits: ball top-left column.
REQ-008 SHALL have port `ball_y`, output, 8 bits: ball top-left row.
REQ-009 SHALL have port `speed_x`, output, 9 bits: horizontal step per frame; never 0.
REQ-010 SHALL have port `speed_y`, output, 8 bits: vertical step per frame.
REQ-011 SHALL have port `ball_right`, output, 1 bit: 1 = moving toward increasing x.
REQ-012 SHALL have port `ball_down`, output, 1 bit: 1 = moving toward increasing y.
REQ-013 SHALL have port `score_left`, output, 1 bit: one-cycle pulse; the left player scored.
REQ-014 SHALL have port `score_right`, output, 1 bit: one-cycle pulse; the right player scored.
REQ-015 SHALL have port `in_play`, output, 1 bit: 1 while in state MOVE.

Function
REQ-016 SHALL implement FSM states IDLE, MOVE and SCORED.
- IDLE -> MOVE: serve = 1.
- MOVE -> SCORED: on a miss.
- SCORED -> IDLE: after HOLD_FRAMES = 30 frame_ticks.
REQ-017 SHALL update position, direction and speed only in MOVE, one cycle after a frame_tick (registered, latency 1); frame_tick in IDLE or SCORED SHALL not move the ball.
REQ-018 SHALL compute the next position as x ± speed_x and y ± speed_y, selected by the direction flags, in 10-bit signed intermediates so that underflow is detectable.
REQ-019 SHALL handle the top wall: if next y <= 0, then y = 0 and ball_down = 1.
REQ-020 SHALL handle the bottom wall: if next y + BALL_SIZE >= 120, then y = 120 - BALL_SIZE and ball_down = 0.
REQ-021 SHALL handle a right paddle hit:
- Condition: ball_right = 1, next x + BALL_SIZE >= 156, and the ball rows overlap [right_paddle_y, right_paddle_y + PADDLE_H).
- Result: x = 156 - BALL_SIZE and ball_right = 0.
REQ-022 SHALL handle a left paddle hit:
- Condition: ball_right = 0, next x <= 4, and the ball overlaps the left paddle rows.
- Result: x = 4 and ball_right = 1.
REQ-023 SHALL handle a miss:
- Right miss: next x >= 160 pulses score_left.
- Left miss: next x < 0 pulses score_right.
- In both cases, in the same cycle as the pulse: x = 78, y = 58, speed_x = 1, and the state enters SCORED.
REQ-024 SHALL apply a wall bounce and a paddle hit in the same tick independently, each flipping its own flag.
REQ-025 SHALL set the serve direction for the next serve toward the side that conceded the last point.
REQ-026 SHALL ignore serve outside IDLE.
REQ-027 SHALL hold all outputs stable between updates.
REQ-028 SHALL never assert score_left and score_right together.

Reset
REQ-029 SHALL, while resetn = 1, drive state IDLE, ball_x = 78, ball_y = 58, speed_x = 1, speed_y = 1, ball_right = 1, ball_down = 1, score pulses 0, in_play 0 and frame counter 0.
REQ-030 SHALL apply reset mid-MOVE or mid-SCORED on the next edge, with no score pulse emitted.

Configuration
REQ-031 SHALL, with BALL_SPEEDUP_EN defined, increment speed_x by 1 on each paddle hit, saturating at MAX_SPEED_X = 4; speed_x SHALL return to 1 on a miss or reset.
REQ-032 SHALL, with BALL_SPEEDUP_EN undefined, hold speed_x at 1 permanently; there SHALL be no speedup logic.

Structure
REQ-033 SHALL place the following in the shared package pong_pkg:
- SCREEN_W = 160, SCREEN_H = 120, BALL_SIZE = 4, PADDLE_H = 16.
- Paddle columns 4 and 156, HOLD_FRAMES, MAX_SPEED_X.
- The FSM state typedef.
REQ-034 SHALL use one combinational sub-module, paddle_overlap: inputs ball_y and paddle_y; output hit.

Verification
REQ-035 SHALL cover free flight: ball (100, 50), moving right and down, speed 1/1, no walls, 1 frame_tick -> (101, 51) exactly one cycle later.
REQ-036 SHALL cover the top wall: y = 1, ball_down = 0, speed_y = 2 -> y = 0, ball_down = 1.
REQ-037 SHALL cover a right paddle hit: x = 151, right_paddle_y = 50, y = 55, speed_x = 1 -> x = 152, ball_right = 0, and speed_x = 2 when BALL_SPEEDUP_EN is defined.
REQ-038 SHALL cover a right miss: x = 155, right_paddle_y = 0, y = 100 -> x reaches >= 160 on a later tick, a single score_left pulse, (78, 58), SCORED, IDLE after 30 ticks, next serve ball_right = 1.
REQ-039 SHALL cover a corner case: y = 1 and a left paddle hit in the same tick -> both ball_down and ball_right flip.
REQ-040 SHALL cover reset mid-MOVE: resetn = 1 for one cycle -> all REQ-029 values, and no score pulse.

Source files
------------

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared constants and FSM state type for the pong ball engine.
//               Screen geometry, ball/paddle sizes, paddle columns, serve
//               position, score hold time and the speedup ceiling.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

  localparam int SCREEN_W       = 160;
  localparam int SCREEN_H       = 120;
  localparam int BALL_SIZE      = 4;
  localparam int PADDLE_H       = 16;

  // Inner faces of the two paddles (columns).
  localparam int LEFT_PADDLE_X  = 4;
  localparam int RIGHT_PADDLE_X = 156;

  // Ball restart position after a point or reset.
  localparam int SERVE_X        = 78;
  localparam int SERVE_Y        = 58;

  localparam int HOLD_FRAMES    = 30;
  localparam int MAX_SPEED_X    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVE   = 2'd1,
    ST_SCORED = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ball_physics_if.sv
`default_nettype none
// ============================================================================
// Module      : ball_physics_if
// Description : Bundle between the game controller (master) and the ball
//               engine (slave).
//   master drives : frame_tick, serve, left_paddle_y, right_paddle_y
//   slave drives  : ball_x, ball_y, speed_x, speed_y, ball_right, ball_down,
//                   score_left, score_right, in_play
// Revision    : 1.0 - initial release
// ============================================================================
interface ball_physics_if;

  logic       frame_tick;
  logic       serve;
  logic [7:0] left_paddle_y;
  logic [7:0] right_paddle_y;

  logic [8:0] ball_x;
  logic [7:0] ball_y;
  logic [8:0] speed_x;
  logic [7:0] speed_y;
  logic       ball_right;
  logic       ball_down;
  logic       score_left;
  logic       score_right;
  logic       in_play;

  modport master (
    output frame_tick, serve, left_paddle_y, right_paddle_y,
    input  ball_x, ball_y, speed_x, speed_y, ball_right, ball_down,
           score_left, score_right, in_play
  );

  modport slave (
    input  frame_tick, serve, left_paddle_y, right_paddle_y,
    output ball_x, ball_y, speed_x, speed_y, ball_right, ball_down,
           score_left, score_right, in_play
  );

endinterface
`default_nettype wire

// File: rtl/ball_physics_paddle_overlap.sv
`default_nettype none
// ============================================================================
// Module      : paddle_overlap
// Description : Combinational test whether the ball rows [ball_y, ball_y+4)
//               intersect the paddle rows [paddle_y, paddle_y+16).
//   ball_y   (in)  : ball top row
//   paddle_y (in)  : paddle top row
//   hit      (out) : 1 when the row ranges intersect
// Revision    : 1.0 - initial release
// ============================================================================
module paddle_overlap
  import pong_pkg::*;
(
  input  logic [7:0] ball_y,
  input  logic [7:0] paddle_y,
  output logic       hit
);

  // 9-bit sums so that a paddle near row 255 cannot wrap.
  logic [8:0] ball_bottom;
  logic [8:0] paddle_bottom;

  assign ball_bottom   = {1'b0, ball_y}   + 9'(BALL_SIZE);
  assign paddle_bottom = {1'b0, paddle_y} + 9'(PADDLE_H);

  assign hit = (ball_bottom > {1'b0, paddle_y}) && ({1'b0, ball_y} < paddle_bottom);

endmodule
`default_nettype wire

// File: rtl/ball_physics.sv
`default_nettype none
// ============================================================================
// Module      : ball_physics
// Description : Pong ball engine. Moves the ball once per frame_tick while in
//               MOVE, bounces off top/bottom walls and both paddles, detects
//               misses, pulses the score of the player who won the point and
//               holds the ball for HOLD_FRAMES frames before the next serve.
//   clk    (in) : system clock, rising edge
//   resetn (in) : synchronous reset, active HIGH despite the name
//   bus         : ball_physics_if.slave (serve/tick/paddles in, ball state out)
// Build option: define BALL_SPEEDUP_EN to add one to speed_x on every paddle
//               hit, saturating at MAX_SPEED_X.
// Revision    : 1.0 - initial release
// ============================================================================
module ball_physics
  import pong_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  ball_physics_if.slave  bus
);

  localparam logic signed [9:0] TOP_LIMIT    = 10'sd0;
  localparam logic signed [9:0] BOTTOM_LIMIT = 10'(SCREEN_H - BALL_SIZE);
  localparam logic signed [9:0] RIGHT_LIMIT  = 10'(RIGHT_PADDLE_X - BALL_SIZE);
  localparam logic signed [9:0] LEFT_LIMIT   = 10'(LEFT_PADDLE_X);
  localparam logic signed [9:0] RIGHT_EDGE   = 10'(SCREEN_W);

  state_t     state;
  logic [4:0] frame_cnt;

  // Signed 10-bit views so a step past column/row 0 shows up as negative.
  logic signed [9:0] x_s, y_s, sx_s, sy_s;
  logic signed [9:0] next_x, next_y;

  logic hit_left_rows, hit_right_rows;
  logic right_hit, right_miss, left_hit, left_miss;

  assign x_s  = signed'({1'b0, bus.ball_x});
  assign y_s  = signed'({2'b00, bus.ball_y});
  assign sx_s = signed'({1'b0, bus.speed_x});
  assign sy_s = signed'({2'b00, bus.speed_y});

  assign next_x = bus.ball_right ? (x_s + sx_s) : (x_s - sx_s);
  assign next_y = bus.ball_down  ? (y_s + sy_s) : (y_s - sy_s);

  paddle_overlap u_left_overlap (
    .ball_y   (bus.ball_y),
    .paddle_y (bus.left_paddle_y),
    .hit      (hit_left_rows)
  );

  paddle_overlap u_right_overlap (
    .ball_y   (bus.ball_y),
    .paddle_y (bus.right_paddle_y),
    .hit      (hit_right_rows)
  );

  // A paddle hit takes priority; the ball only scores if it gets past.
  assign right_hit  =  bus.ball_right && (next_x >= RIGHT_LIMIT) && hit_right_rows;
  assign right_miss =  bus.ball_right && !right_hit && (next_x >= RIGHT_EDGE);
  assign left_hit   = !bus.ball_right && (next_x <= LEFT_LIMIT) && hit_left_rows;
  assign left_miss  = !bus.ball_right && !left_hit && (next_x < 10'sd0);

`ifdef BALL_SPEEDUP_EN
  logic [8:0] speed_x_up;
  assign speed_x_up = (bus.speed_x >= 9'(MAX_SPEED_X)) ? 9'(MAX_SPEED_X)
                                                       : bus.speed_x + 9'd1;
`endif

  always_ff @(posedge clk) begin
    if (resetn) begin
      state           <= ST_IDLE;
      frame_cnt       <= 5'd0;
      bus.ball_x      <= 9'(SERVE_X);
      bus.ball_y      <= 8'(SERVE_Y);
      bus.speed_x     <= 9'd1;
      bus.speed_y     <= 8'd1;
      bus.ball_right  <= 1'b1;
      bus.ball_down   <= 1'b1;
      bus.score_left  <= 1'b0;
      bus.score_right <= 1'b0;
      bus.in_play     <= 1'b0;
    end else begin
      bus.score_left  <= 1'b0;
      bus.score_right <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.serve) begin
            state       <= ST_MOVE;
            bus.in_play <= 1'b1;
          end
        end

        ST_MOVE: begin
          if (bus.frame_tick) begin
            // Vertical motion and wall bounce.
            if (next_y <= TOP_LIMIT) begin
              bus.ball_y    <= 8'd0;
              bus.ball_down <= 1'b1;
            end else if (next_y >= BOTTOM_LIMIT) begin
              bus.ball_y    <= BOTTOM_LIMIT[7:0];
              bus.ball_down <= 1'b0;
            end else begin
              bus.ball_y    <= next_y[7:0];
            end

            // Horizontal motion, paddle bounce and scoring.
            if (right_miss || left_miss) begin
              state           <= ST_SCORED;
              frame_cnt       <= 5'd0;
              bus.in_play     <= 1'b0;
              bus.ball_x      <= 9'(SERVE_X);
              bus.ball_y      <= 8'(SERVE_Y);
              bus.speed_x     <= 9'd1;
              bus.score_left  <= right_miss;
              bus.score_right <= left_miss;
              // Next serve heads toward the side that conceded.
              bus.ball_right  <= right_miss;
            end else if (right_hit) begin
              bus.ball_x     <= RIGHT_LIMIT[8:0];
              bus.ball_right <= 1'b0;
`ifdef BALL_SPEEDUP_EN
              bus.speed_x    <= speed_x_up;
`endif
            end else if (left_hit) begin
              bus.ball_x     <= LEFT_LIMIT[8:0];
              bus.ball_right <= 1'b1;
`ifdef BALL_SPEEDUP_EN
              bus.speed_x    <= speed_x_up;
`endif
            end else begin
              bus.ball_x <= next_x[8:0];
            end
          end
        end

        ST_SCORED: begin
          if (bus.frame_tick) begin
            if (frame_cnt == 5'(HOLD_FRAMES - 1)) begin
              state     <= ST_IDLE;
              frame_cnt <= 5'd0;
            end else begin
              frame_cnt <= frame_cnt + 5'd1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ball_physics.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_physics
// Description : Directed self-checking bench for ball_physics. Drives serves,
//               frame ticks and paddle rows; compares the ball state against
//               hand-computed trajectory values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_physics;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  ball_physics_if bus ();

  ball_physics dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit track  = 1'b0;
  int n_ticks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One frame_tick pulse; returns at the negedge after the update edge.
  // With track set, both paddles follow the ball so it is always returned.
  task automatic tick();
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    if (track) begin
      bus.left_paddle_y  = (bus.ball_y >= 8'd6) ? bus.ball_y - 8'd6 : 8'd0;
      bus.right_paddle_y = bus.left_paddle_y;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic serve_once();
    bus.serve = 1'b1;
    @(negedge clk);
    bus.serve = 1'b0;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_x"},       32'(bus.ball_x),      32'd78);
    chk({pfx, "_y"},       32'(bus.ball_y),      32'd58);
    chk({pfx, "_sx"},      32'(bus.speed_x),     32'd1);
    chk({pfx, "_sy"},      32'(bus.speed_y),     32'd1);
    chk({pfx, "_right"},   32'(bus.ball_right),  32'd1);
    chk({pfx, "_down"},    32'(bus.ball_down),   32'd1);
    chk({pfx, "_scl"},     32'(bus.score_left),  32'd0);
    chk({pfx, "_scr"},     32'(bus.score_right), 32'd0);
    chk({pfx, "_in_play"}, 32'(bus.in_play),     32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.frame_tick     = 1'b0;
    bus.serve          = 1'b0;
    bus.left_paddle_y  = 8'd0;
    bus.right_paddle_y = 8'd0;
    resetn             = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    resetn = 1'b0;

    // frame_tick in IDLE must not move the ball.
    tick();
    chk("idle_tick_x", 32'(bus.ball_x), 32'd78);
    chk("idle_in_play", 32'(bus.in_play), 32'd0);

    // First serve: right and down from (78,58).
    serve_once();
    chk("serve1_in_play", 32'(bus.in_play), 32'd1);
    tick();
    chk("free_x", 32'(bus.ball_x), 32'd79);
    chk("free_y", 32'(bus.ball_y), 32'd59);

    // Tick 58: next y = 116 reaches the bottom wall.
    ticks(57);
    chk("bottom_x",    32'(bus.ball_x),    32'd136);
    chk("bottom_y",    32'(bus.ball_y),    32'd116);
    chk("bottom_down", 32'(bus.ball_down), 32'd0);

    // Right paddle far away at row 0: ball misses on tick 82 (next x = 160).
    bus.right_paddle_y = 8'd0;
    ticks(23);
    chk("pre_miss_x",   32'(bus.ball_x),     32'd159);
    chk("pre_miss_scl", 32'(bus.score_left), 32'd0);
    tick();
    chk("rmiss_scl",     32'(bus.score_left),  32'd1);
    chk("rmiss_scr",     32'(bus.score_right), 32'd0);
    chk("rmiss_x",       32'(bus.ball_x),      32'd78);
    chk("rmiss_y",       32'(bus.ball_y),      32'd58);
    chk("rmiss_sx",      32'(bus.speed_x),     32'd1);
    chk("rmiss_in_play", 32'(bus.in_play),     32'd0);
    chk("rmiss_right",   32'(bus.ball_right),  32'd1);
    @(negedge clk);
    chk("rmiss_pulse_1cyc", 32'(bus.score_left), 32'd0);

    // Serve held high through 29 hold ticks is ignored; after the 30th it works.
    bus.serve = 1'b1;
    ticks(29);
    chk("scored_serve_ignored", 32'(bus.in_play), 32'd0);
    chk("scored_x_hold",        32'(bus.ball_x),  32'd78);
    bus.serve = 1'b0;
    tick();
    serve_once();
    chk("serve2_in_play", 32'(bus.in_play), 32'd1);

    // Second serve: right, up (down flag stayed 0). Top wall on tick 58.
    ticks(58);
    chk("top_x",    32'(bus.ball_x),    32'd136);
    chk("top_y",    32'(bus.ball_y),    32'd0);
    chk("top_down", 32'(bus.ball_down), 32'd1);

    // Right paddle at row 10 covers ball row 15: hit on tick 74.
    bus.right_paddle_y = 8'd10;
    ticks(16);
    chk("rhit_x",     32'(bus.ball_x),     32'd152);
    chk("rhit_y",     32'(bus.ball_y),     32'd16);
    chk("rhit_right", 32'(bus.ball_right), 32'd0);
`ifdef BALL_SPEEDUP_EN
    chk("rhit_sx",    32'(bus.speed_x),    32'd2);
`else
    chk("rhit_sx",    32'(bus.speed_x),    32'd1);
`endif

    // Left paddle out of reach: ball leaves past column 0.
    bus.left_paddle_y = 8'd200;
    n_ticks = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      n_ticks++;
      if (bus.score_left || bus.score_right) break;
    end
    chk("lmiss_scr",   32'(bus.score_right), 32'd1);
    chk("lmiss_scl",   32'(bus.score_left),  32'd0);
    chk("lmiss_x",     32'(bus.ball_x),      32'd78);
    chk("lmiss_sx",    32'(bus.speed_x),     32'd1);
    chk("lmiss_right", 32'(bus.ball_right),  32'd0);
`ifdef BALL_SPEEDUP_EN
    chk("lmiss_ticks", 32'(n_ticks), 32'd77);
`else
    chk("lmiss_ticks", 32'(n_ticks), 32'd153);
`endif
    @(negedge clk);
    ticks(30);
    serve_once();
    chk("serve3_in_play", 32'(bus.in_play), 32'd1);
    ticks(3);
    chk("serve3_left_x", 32'(bus.ball_x), 32'd75);

    // Reset for one cycle while in MOVE.
    resetn = 1'b1;
    @(negedge clk);
    chk_reset("mid_rst");
    resetn = 1'b0;
    @(negedge clk);
    chk("post_rst_scl", 32'(bus.score_left),  32'd0);
    chk("post_rst_scr", 32'(bus.score_right), 32'd0);
    chk("post_rst_x",   32'(bus.ball_x),      32'd78);

`ifndef BALL_SPEEDUP_EN
    // Long rally with tracking paddles. In unfolded coordinates the ball
    // sits at (78+k, 58+k); column bounces repeat every 296, row bounces
    // every 232. At k = 6438 the left paddle and the top wall coincide.
    track = 1'b1;
    bus.left_paddle_y  = 8'd52;
    bus.right_paddle_y = 8'd52;
    serve_once();
    ticks(6437);
    chk("corner_pre_x",     32'(bus.ball_x),     32'd5);
    chk("corner_pre_y",     32'(bus.ball_y),     32'd1);
    chk("corner_pre_right", 32'(bus.ball_right), 32'd0);
    chk("corner_pre_down",  32'(bus.ball_down),  32'd0);
    tick();
    chk("corner_x",       32'(bus.ball_x),     32'd4);
    chk("corner_y",       32'(bus.ball_y),     32'd0);
    chk("corner_right",   32'(bus.ball_right), 32'd1);
    chk("corner_down",    32'(bus.ball_down),  32'd1);
    chk("corner_in_play", 32'(bus.in_play),    32'd1);
    track = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
